// File: rtl/block_swap_ctrl.sv
// block_swap_ctrl: tag-table lookup of request addresses onto SRAM slots plus a single-job fill FSM.
// Latency: lookup 0 cycles; fill_req_o rises 1 cycle after a miss, hit visible 1 cycle after fill_done_i.
// Backpressure: block_o stalls requestors on any miss; the fill job is held until fill_ack_i. Option: BLOCK_SWAP_STATS_EN.
module block_swap_ctrl #(
    parameter int NumReq       = 2,
    parameter int NumSlots     = 8,
    parameter int AddrWidth    = 21,
    parameter int BlockOffsetW = 12,
    localparam int IdxW        = $clog2(NumSlots),
    localparam int TagW        = AddrWidth - BlockOffsetW
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumReq*AddrWidth-1:0] req_addr_i,
    input  logic [NumReq-1:0]           valid_i,
    output logic [NumReq*IdxW-1:0]      sram_addr_idx_o,
    output logic                        block_o,
    input  logic                        flush_i,
    output logic                        fill_req_o,
    output logic [AddrWidth-1:0]        fill_addr_o,
    output logic [IdxW-1:0]             fill_slot_o,
    input  logic                        fill_ack_i,
    input  logic                        fill_done_i
`ifdef BLOCK_SWAP_STATS_EN
    ,
    output logic [31:0]                 hit_cnt_o,
    output logic [31:0]                 miss_cnt_o
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

    state_t               state_q, state_d;
    logic [NumSlots-1:0]  vld_q, vld_d;
    logic [TagW-1:0]      tag_q [NumSlots];
    logic [TagW-1:0]      tag_d [NumSlots];
    logic [IdxW-1:0]      rr_q, rr_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [AddrWidth-1:0] fill_addr_q, fill_addr_d;
    logic [IdxW-1:0]      fill_slot_q, fill_slot_d;

    logic [NumReq-1:0]             hit;
    logic [NumReq-1:0]             miss;
    logic [NumReq*IdxW-1:0]        idx;
    logic [TagW-1:0]               miss_tag;
    logic [IdxW-1:0]               victim;
    logic                          fill_start;
    logic [NumReq*BlockOffsetW-1:0] unused_offset;

    // Tags are unique in the table, so at most one slot can match per port.
    always_comb begin
        hit = '0;
        idx = '0;
        unused_offset = '0;
        for (int i = 0; i < NumReq; i++) begin
            unused_offset[i*BlockOffsetW +: BlockOffsetW] = req_addr_i[i*AddrWidth +: BlockOffsetW];
            for (int s = 0; s < NumSlots; s++) begin
                if (valid_i[i] && vld_q[s] &&
                    tag_q[s] == req_addr_i[i*AddrWidth+BlockOffsetW +: TagW]) begin
                    hit[i] = 1'b1;
                    idx[i*IdxW +: IdxW] = IdxW'(s);
                end
            end
        end
    end

    assign miss            = valid_i & ~hit;
    assign block_o         = |miss;
    assign sram_addr_idx_o = idx;

    // Lowest missing port wins; victim prefers the lowest empty slot before evicting at rr_q.
    always_comb begin
        miss_tag = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (miss[i]) begin
                miss_tag = req_addr_i[i*AddrWidth+BlockOffsetW +: TagW];
            end
        end
        victim = rr_q;
        for (int s = NumSlots - 1; s >= 0; s--) begin
            if (!vld_q[s]) begin
                victim = IdxW'(s);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        vld_d        = vld_q;
        tag_d        = tag_q;
        rr_d         = rr_q;
        flush_pend_d = flush_pend_q;
        fill_addr_d  = fill_addr_q;
        fill_slot_d  = fill_slot_q;
        fill_start   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (flush_i || flush_pend_q) begin
                    vld_d        = '0;
                    flush_pend_d = 1'b0;
                end else if (|miss) begin
                    fill_start    = 1'b1;
                    vld_d[victim] = 1'b0;
                    fill_slot_d   = victim;
                    fill_addr_d   = {miss_tag, {BlockOffsetW{1'b0}}};
                    state_d       = ST_REQ;
                end
            end
            ST_REQ: begin
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (fill_ack_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (fill_done_i) begin
                    // A flush seen during the fill discards the new entry; IDLE then wipes the table.
                    if (!(flush_i || flush_pend_q)) begin
                        vld_d[fill_slot_q] = 1'b1;
                        tag_d[fill_slot_q] = fill_addr_q[AddrWidth-1:BlockOffsetW];
                    end
                    if (fill_slot_q == rr_q) begin
                        rr_d = (rr_q == IdxW'(NumSlots - 1)) ? '0 : rr_q + IdxW'(1);
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            vld_q        <= '0;
            rr_q         <= '0;
            flush_pend_q <= 1'b0;
            fill_addr_q  <= '0;
            fill_slot_q  <= '0;
            for (int s = 0; s < NumSlots; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            state_q      <= state_d;
            vld_q        <= vld_d;
            tag_q        <= tag_d;
            rr_q         <= rr_d;
            flush_pend_q <= flush_pend_d;
            fill_addr_q  <= fill_addr_d;
            fill_slot_q  <= fill_slot_d;
        end
    end

    assign fill_req_o  = (state_q == ST_REQ);
    assign fill_addr_o = fill_addr_q;
    assign fill_slot_o = fill_slot_q;

`ifdef BLOCK_SWAP_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic [32:0] hit_sum;

    always_comb begin
        hit_sum = {1'b0, hit_cnt_q};
        for (int i = 0; i < NumReq; i++) begin
            hit_sum = hit_sum + {32'd0, hit[i]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_sum[32] ? '1 : hit_sum[31:0];
            if (fill_start && miss_cnt_q != '1) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
